// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost monitor: FSM state encoding and the tohost pass word.
// Optional console feature is enabled with `define TOHOST_CONSOLE_EN.
package tohost_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] TOHOST_PASS = 32'h1;

endpackage

// File: rtl/tohost_monitor_if.sv
// Store bus into the tohost monitor.
// Handshake: a store transfers on a rising clk edge where wr_valid && wr_ready; addr/data/strb are
// sampled on that edge and the master holds them stable while wr_valid is high and wr_ready is low.
interface tohost_monitor_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  modport master (output wr_valid, wr_addr, wr_data, wr_strb, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_strb, output wr_ready);
endinterface

// File: rtl/tohost_monitor_cycle_watchdog.sv
// Saturating RUN-cycle counter with an expiry compare against a programmable limit.
// Used by tohost_monitor (macro TOHOST_CONSOLE_EN does not affect this block).
module cycle_watchdog #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is only meaningful while counting; the caller decides what it overrides.
  assign expired = en && (cnt == limit);

endmodule

// File: rtl/tohost_monitor.sv
// Device end of the riscv-tests tohost protocol: decodes the verdict word, runs a watchdog,
// and holds a sticky done/pass/fail_num verdict. `define TOHOST_CONSOLE_EN adds a console byte port.
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          CNT_W          = 32
`ifdef TOHOST_CONSOLE_EN
  ,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1040
`endif
) (
  input  logic                clk,
  input  logic                rst,
  tohost_monitor_if.slave     bus,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [30:0]         fail_num,
  output logic [CNT_W-1:0]    cycle_cnt,
  output state_t              state_dbg
`ifdef TOHOST_CONSOLE_EN
  ,
  output logic                con_valid,
  output logic [7:0]          con_data
`endif
);

  state_t state;
  state_t state_nx;
  logic   accept;
  logic   verdict_hit;
  logic   expired;

  assign accept      = bus.wr_valid && bus.wr_ready;
  // Only odd values are verdicts; even values are syscalls the bench program may issue.
  assign verdict_hit = accept && (state == ST_RUN) && (bus.wr_addr == TOHOST_ADDR) &&
                       (bus.wr_strb == 4'hF) && bus.wr_data[0];

  cycle_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_RUN),
    .limit   (CNT_W'(TIMEOUT_CYCLES - 1)),
    .cnt     (cycle_cnt),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_RUN;
      ST_RUN:  if (verdict_hit || expired) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready = (state != ST_IDLE);
    done         = (state == ST_DONE);
    state_dbg    = state;
  end

  // A verdict write on the expiry cycle takes priority over the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass     <= 1'b0;
      timeout  <= 1'b0;
      fail_num <= '0;
    end else if (state == ST_RUN) begin
      if (verdict_hit) begin
        pass     <= (bus.wr_data == TOHOST_PASS);
        fail_num <= (bus.wr_data == TOHOST_PASS) ? 31'd0 : bus.wr_data[31:1];
      end else if (expired) begin
        timeout  <= 1'b1;
      end
    end
  end

`ifdef TOHOST_CONSOLE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      con_valid <= 1'b0;
      con_data  <= 8'h00;
    end else begin
      con_valid <= accept && (bus.wr_addr == CONSOLE_ADDR) && bus.wr_strb[0];
      if (accept && (bus.wr_addr == CONSOLE_ADDR) && bus.wr_strb[0]) begin
        con_data <= bus.wr_data[7:0];
      end
    end
  end
`endif

endmodule
